// File: rtl/legv8_pkg.sv
// legv8_pkg: shared types and constants for the LEGv8 fetch front end.
//   INSTR_W / ADDR_W     : instruction and address widths
//   PC_STEP              : sequential fetch increment
//   DEFAULT_HALT_WORD    : default halt sentinel encoding
//   fetch_state_t        : fetch FSM states
//   pc_sel_t             : next-PC source select
//   ifid_t               : IF/ID pipeline register contents
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [ADDR_W-1:0]  PC_STEP           = 64'd4;
    localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_RESET  = 2'd0,
        SEL_TARGET = 2'd1,
        SEL_HOLD   = 2'd2,
        SEL_INC    = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } ifid_t;

endpackage

// File: rtl/legv8_next_pc.sv
// legv8_next_pc: combinational next-PC mux.
//   sel           : source select from the fetch priority decode
//   pc            : current registered PC
//   branch_target : redirect address (low two bits dropped here)
//   next_pc       : value the PC register loads on the next edge
module legv8_next_pc
    import legv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  pc_sel_t           sel,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        unique case (sel)
            SEL_RESET:  next_pc = RESET_PC;
            SEL_TARGET: next_pc = {branch_target[ADDR_W-1:2], 2'b00};
            SEL_HOLD:   next_pc = pc;
            SEL_INC:    next_pc = pc + PC_STEP;   // wraps naturally at 2^64
            default:    next_pc = pc;
        endcase
    end

endmodule

// File: rtl/legv8_fetch_stage.sv
// legv8_fetch_stage: LEGv8 instruction fetch with IF/ID register.
//   CLOCK, RESET            : clock, synchronous active-high reset
//   PC                      : registered fetch address to combinational imem
//   IMEM_INSTRUCTION        : imem data for PC, same cycle
//   STALL                   : hold request from decode/hazard logic
//   BRANCH_TAKEN/TARGET     : redirect + flush request from the core
//   IFID_VALID/INSTRUCTION/PC : IF/ID register outputs
//   HALTED                  : parked on the halt sentinel
//   FETCH_COUNT             : saturating count of delivered instructions
module legv8_fetch_stage
    import legv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 64'h0,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD,
    parameter int                 COUNT_W   = 32
) (
    input  logic               CLOCK,
    input  logic               RESET,
    output logic [ADDR_W-1:0]  PC,
    input  logic [INSTR_W-1:0] IMEM_INSTRUCTION,
    input  logic               STALL,
    input  logic               BRANCH_TAKEN,
    input  logic [ADDR_W-1:0]  BRANCH_TARGET,
    output logic               IFID_VALID,
    output logic [INSTR_W-1:0] IFID_INSTRUCTION,
    output logic [ADDR_W-1:0]  IFID_PC,
    output logic               HALTED,
    output logic [COUNT_W-1:0] FETCH_COUNT
);

    fetch_state_t       state, state_nx;
    pc_sel_t            pc_sel;
    logic [ADDR_W-1:0]  pc_q, pc_nx;
    ifid_t              ifid_q;
    logic [COUNT_W-1:0] count_q;
    logic               is_halt_word;
    logic               deliver;

    assign is_halt_word = (IMEM_INSTRUCTION == HALT_WORD);

    // A word is handed to IF/ID only on an unobstructed FETCH cycle that
    // did not read the sentinel.
    assign deliver = !BRANCH_TAKEN && !STALL && (state == FETCH) && !is_halt_word;

    always_comb begin
        pc_sel   = SEL_HOLD;
        state_nx = state;
        if (RESET) begin
            pc_sel   = SEL_RESET;
            state_nx = FETCH;
        end else if (BRANCH_TAKEN) begin
            // Sentinel may have been fetched down a wrong path; leave HALT.
            pc_sel   = SEL_TARGET;
            state_nx = FETCH;
        end else if (STALL) begin
            pc_sel   = SEL_HOLD;
        end else if (state == FETCH) begin
            if (is_halt_word) state_nx = HALT;
            else              pc_sel   = SEL_INC;
        end
    end

    legv8_next_pc #(.RESET_PC(RESET_PC)) u_next_pc (
        .sel           (pc_sel),
        .pc            (pc_q),
        .branch_target (BRANCH_TARGET),
        .next_pc       (pc_nx)
    );

    always_ff @(posedge CLOCK) begin
        pc_q  <= pc_nx;
        state <= state_nx;
        if (RESET) begin
            ifid_q  <= '0;
            count_q <= '0;
        end else if (BRANCH_TAKEN) begin
            ifid_q.valid <= 1'b0;
        end else if (deliver) begin
            ifid_q.valid <= 1'b1;
            ifid_q.instr <= IMEM_INSTRUCTION;
            ifid_q.pc    <= pc_q;
            if (count_q != {COUNT_W{1'b1}}) count_q <= count_q + COUNT_W'(1);
        end else if (!STALL || state == HALT) begin
            // Sentinel hit, or parked: bubble into IF/ID.
            ifid_q.valid <= 1'b0;
        end
    end

    assign PC               = pc_q;
    assign IFID_VALID       = ifid_q.valid;
    assign IFID_INSTRUCTION = ifid_q.instr;
    assign IFID_PC          = ifid_q.pc;
    assign HALTED           = (state == HALT);
    assign FETCH_COUNT      = count_q;

endmodule

// File: tb/tb_legv8_fetch_stage.sv
module tb_legv8_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, br;
    logic [63:0] tgt;
    logic [31:0] word_c;
    int          errors = 0;
    int          checks = 0;

    logic [63:0] pc_a, pc_b, ifid_pc_a, ifid_pc_b;
    logic [31:0] im_a, im_b, ifid_in_a, ifid_in_b;
    logic        v_a, v_b, h_a, h_b;
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a, input logic [31:0] wc);
        case (a)
            64'h0:   return 32'h8B02_0020;
            64'h4:   return 32'hCB03_0041;
            64'h8:   return 32'hF840_0062;
            64'hC:   return wc;
            default: return {16'hD503, a[15:0]};
        endcase
    endfunction

    assign im_a = imem(pc_a, word_c);
    assign im_b = imem(pc_b, word_c);

    legv8_fetch_stage #(.COUNT_W(32)) dut (
        .CLOCK(clk), .RESET(rst), .PC(pc_a), .IMEM_INSTRUCTION(im_a),
        .STALL(stall), .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt),
        .IFID_VALID(v_a), .IFID_INSTRUCTION(ifid_in_a), .IFID_PC(ifid_pc_a),
        .HALTED(h_a), .FETCH_COUNT(cnt_a)
    );

    legv8_fetch_stage #(.COUNT_W(2)) dut2 (
        .CLOCK(clk), .RESET(rst), .PC(pc_b), .IMEM_INSTRUCTION(im_b),
        .STALL(stall), .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt),
        .IFID_VALID(v_b), .IFID_INSTRUCTION(ifid_in_b), .IFID_PC(ifid_pc_b),
        .HALTED(h_b), .FETCH_COUNT(cnt_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; br = 0; tgt = '0; word_c = 32'h1111_0000;
        step(); step();
        checks++; if (pc_a !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_a, 64'h0); end
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v_a); end
        checks++; if (ifid_in_a !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", ifid_in_a); end
        checks++; if (ifid_pc_a !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h want 0", ifid_pc_a); end
        checks++; if (h_a !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", h_a); end
        checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    endtask

    task automatic test_free_run();
        rst = 0;
        step();
        checks++; if (ifid_pc_a !== 64'h0 || v_a !== 1'b1) begin errors++; $display("FAIL run1_ifid: got pc=%h v=%b want pc=0 v=1", ifid_pc_a, v_a); end
        checks++; if (ifid_in_a !== 32'h8B02_0020) begin errors++; $display("FAIL run1_instr: got %h want 8b020020", ifid_in_a); end
        checks++; if (pc_a !== 64'h4 || cnt_a !== 32'd1) begin errors++; $display("FAIL run1_pc_cnt: got pc=%h cnt=%0d want 4/1", pc_a, cnt_a); end
        step();
        checks++; if (ifid_pc_a !== 64'h4 || ifid_in_a !== 32'hCB03_0041) begin errors++; $display("FAIL run2_ifid: got pc=%h in=%h want 4/cb030041", ifid_pc_a, ifid_in_a); end
        checks++; if (pc_a !== 64'h8 || cnt_a !== 32'd2) begin errors++; $display("FAIL run2_pc_cnt: got pc=%h cnt=%0d want 8/2", pc_a, cnt_a); end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (pc_a !== 64'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 8", i, pc_a); end
            checks++; if (ifid_pc_a !== 64'h4 || v_a !== 1'b1 || ifid_in_a !== 32'hCB03_0041) begin errors++; $display("FAIL stall_ifid[%0d]: got pc=%h v=%b in=%h want 4/1/cb030041", i, ifid_pc_a, v_a, ifid_in_a); end
            checks++; if (cnt_a !== 32'd2) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d want 2", i, cnt_a); end
        end
        stall = 0;
        step();
        checks++; if (ifid_pc_a !== 64'h8 || ifid_in_a !== 32'hF840_0062) begin errors++; $display("FAIL unstall_ifid: got pc=%h in=%h want 8/f8400062", ifid_pc_a, ifid_in_a); end
        checks++; if (pc_a !== 64'hC || cnt_a !== 32'd3) begin errors++; $display("FAIL unstall_pc_cnt: got pc=%h cnt=%0d want c/3", pc_a, cnt_a); end
    endtask

    task automatic test_halt();
        word_c = 32'h0;
        step();
        checks++; if (h_a !== 1'b1 || pc_a !== 64'hC) begin errors++; $display("FAIL halt_enter: got h=%b pc=%h want 1/c", h_a, pc_a); end
        checks++; if (v_a !== 1'b0 || cnt_a !== 32'd3) begin errors++; $display("FAIL halt_bubble: got v=%b cnt=%0d want 0/3", v_a, cnt_a); end
        stall = 1;
        step();
        checks++; if (h_a !== 1'b1 || pc_a !== 64'hC || v_a !== 1'b0 || cnt_a !== 32'd3) begin errors++; $display("FAIL halt_hold: got h=%b pc=%h v=%b cnt=%0d want 1/c/0/3", h_a, pc_a, v_a, cnt_a); end
        stall = 0; br = 1; tgt = 64'h4;
        step();
        checks++; if (h_a !== 1'b0 || pc_a !== 64'h4 || v_a !== 1'b0) begin errors++; $display("FAIL halt_exit: got h=%b pc=%h v=%b want 0/4/0", h_a, pc_a, v_a); end
        br = 0;
        step();
        checks++; if (ifid_pc_a !== 64'h4 || v_a !== 1'b1 || cnt_a !== 32'd4 || pc_a !== 64'h8) begin errors++; $display("FAIL halt_resume: got ipc=%h v=%b cnt=%0d pc=%h want 4/1/4/8", ifid_pc_a, v_a, cnt_a, pc_a); end
    endtask

    task automatic test_branch_stall();
        br = 1; stall = 1; tgt = 64'h40;
        step();
        checks++; if (pc_a !== 64'h40 || v_a !== 1'b0 || cnt_a !== 32'd4) begin errors++; $display("FAIL brst_redirect: got pc=%h v=%b cnt=%0d want 40/0/4", pc_a, v_a, cnt_a); end
        br = 0; stall = 0;
        step();
        checks++; if (ifid_pc_a !== 64'h40 || v_a !== 1'b1 || ifid_in_a !== 32'hD503_0040) begin errors++; $display("FAIL brst_deliver: got pc=%h v=%b in=%h want 40/1/d5030040", ifid_pc_a, v_a, ifid_in_a); end
        checks++; if (cnt_a !== 32'd5 || pc_a !== 64'h44) begin errors++; $display("FAIL brst_cnt_pc: got cnt=%0d pc=%h want 5/44", cnt_a, pc_a); end
        br = 1; tgt = 64'h43;
        step();
        checks++; if (pc_a !== 64'h40) begin errors++; $display("FAIL target_align: got %h want 40", pc_a); end
        br = 0;
    endtask

    task automatic test_reset_mid();
        br = 1; tgt = 64'hC;
        step();
        br = 0;
        step();
        checks++; if (h_a !== 1'b1) begin errors++; $display("FAIL rst_pre_halt: got %b want 1", h_a); end
        rst = 1;
        step();
        checks++; if (pc_a !== 64'h0 || h_a !== 1'b0 || v_a !== 1'b0 || cnt_a !== 32'd0) begin errors++; $display("FAIL rst_from_halt: got pc=%h h=%b v=%b cnt=%0d want 0/0/0/0", pc_a, h_a, v_a, cnt_a); end
        checks++; if (ifid_pc_a !== 64'h0 || ifid_in_a !== 32'h0) begin errors++; $display("FAIL rst_from_halt_ifid: got pc=%h in=%h want 0/0", ifid_pc_a, ifid_in_a); end
        rst = 0; word_c = 32'h1111_0000;
        step();
        checks++; if (v_a !== 1'b1 || cnt_a !== 32'd1) begin errors++; $display("FAIL rst_refetch: got v=%b cnt=%0d want 1/1", v_a, cnt_a); end
        stall = 1; rst = 1;
        step();
        checks++; if (pc_a !== 64'h0 || v_a !== 1'b0 || cnt_a !== 32'd0 || ifid_in_a !== 32'h0 || h_a !== 1'b0) begin errors++; $display("FAIL rst_from_stall: got pc=%h v=%b cnt=%0d in=%h h=%b want 0/0/0/0/0", pc_a, v_a, cnt_a, ifid_in_a, h_a); end
        stall = 0; rst = 0;
    endtask

    task automatic test_wrap_saturate();
        br = 1; tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        checks++; if (pc_a !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_preload: got %h want fffffffffffffffc", pc_a); end
        br = 0;
        step();
        checks++; if (pc_a !== 64'h0 || ifid_pc_a !== 64'hFFFF_FFFF_FFFF_FFFC || v_a !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc=%h ipc=%h v=%b want 0/fffffffffffffffc/1", pc_a, ifid_pc_a, v_a); end
        step(); step(); step();
        checks++; if (cnt_b !== 2'd3 || cnt_a !== 32'd4) begin errors++; $display("FAIL sat_4: got narrow=%0d wide=%0d want 3/4", cnt_b, cnt_a); end
        step();
        checks++; if (cnt_b !== 2'd3 || cnt_a !== 32'd5) begin errors++; $display("FAIL sat_5: got narrow=%0d wide=%0d want 3/5", cnt_b, cnt_a); end
        checks++; if (pc_b !== pc_a || ifid_pc_b !== ifid_pc_a) begin errors++; $display("FAIL narrow_tracks: got pc=%h ipc=%h want %h/%h", pc_b, ifid_pc_b, pc_a, ifid_pc_a); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_halt();
        test_branch_stall();
        test_reset_mid();
        test_wrap_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
